dpo_arb: RTL and testbench

//  Round-robin scheduler sharing the FX3 GPIFII slave-FIFO bus between N output data-port FSMs (DP1/2/3).

---
 rtl/dpo_arb_if.sv | 27 ++
 rtl/dpo_arb.sv | 134 +++++++++++++
 tb/tb_dpo_arb.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dpo_arb_if.sv
// Bus between dpo_arb and the per-port output FSMs:
// requests, done pulses, start pulses, bus owner and FX3 thread address.
interface dpo_arb_if #(
    parameter int N_PORTS = 3
);
    logic [N_PORTS-1:0] req;
    logic [N_PORTS-1:0] done;
    logic [N_PORTS-1:0] strt;
    logic [N_PORTS-1:0] sel;
    logic [1:0]         fx3_addr;

    modport master (
        input  req,
        input  done,
        output strt,
        output sel,
        output fx3_addr
    );

    modport slave (
        output req,
        output done,
        input  strt,
        input  sel,
        input  fx3_addr
    );
endinterface

// File: rtl/dpo_arb.sv
// Round-robin owner of the FX3 slave-FIFO bus across the output data ports:
// address setup, start pulse, wait for done or timeout, then release.
module dpo_arb #(
    parameter int         N_PORTS   = 3,
    parameter logic [1:0] ADDR_OFS  = 2'd1,
    parameter int         SETUP_CYC = 3,
    parameter int         TIMEOUT   = 1024
) (
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  logic      en_i,
    dpo_arb_if.master bus,
    output logic      busy_o,
    output logic      tmout_o
);
    localparam int GW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int CMAX = (SETUP_CYC > TIMEOUT) ? SETUP_CYC : TIMEOUT;
    localparam int CW = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_SETUP,
        START,
        WAIT_DONE,
        RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [GW-1:0]      g_q, g_d;
    logic [GW-1:0]      ptr_q, ptr_d;
    logic [N_PORTS-1:0] sel_q, sel_d;
    logic [N_PORTS-1:0] strt_q, strt_d;
    logic [1:0]         addr_q, addr_d;
    logic               busy_q, busy_d;
    logic               tmout_q, tmout_d;

    logic               pick_vld;
    logic [GW-1:0]      pick;
    logic [GW-1:0]      cand;

    // First requester after the last owner, wrapping at N_PORTS
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        cand     = '0;
        for (int i = 1; i <= N_PORTS; i++) begin
            cand = GW'((int'(ptr_q) + i) % N_PORTS);
            if (!pick_vld && bus.req[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        strt_d  = '0;
        addr_d  = addr_q;
        tmout_d = tmout_q;
        unique case (state_q)
            IDLE: begin
                if (en_i && pick_vld) begin
                    g_d     = pick;
                    sel_d   = N_PORTS'(1) << pick;
                    addr_d  = ADDR_OFS + 2'(pick);
                    cnt_d   = '0;
                    state_d = ADDR_SETUP;
                end
            end
            ADDR_SETUP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(SETUP_CYC - 1)) begin
                    state_d = START;
                end
            end
            START: begin
                strt_d  = N_PORTS'(1) << g_q;
                cnt_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.done[g_q]) begin
                    state_d = RELEASE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    tmout_d = 1'b1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                sel_d   = '0;
                ptr_d   = g_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            g_q     <= '0;
            ptr_q   <= GW'(N_PORTS - 1);
            sel_q   <= '0;
            strt_q  <= '0;
            addr_q  <= ADDR_OFS;
            busy_q  <= 1'b0;
            tmout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            strt_q  <= strt_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            tmout_q <= tmout_d;
        end
    end

    assign bus.strt     = strt_q;
    assign bus.sel      = sel_q;
    assign bus.fx3_addr = addr_q;
    assign busy_o       = busy_q;
    assign tmout_o      = tmout_q;
endmodule

// File: tb/tb_dpo_arb.sv
// Bench for dpo_arb: directed and random grants checked against a
// transaction-level round-robin model with fixed setup/timeout timing.
module tb_dpo_arb;
    localparam int N = 3;
    localparam int TMO = 1024;
    localparam int SETUP = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic busy;
    logic tmout;

    int n_cmp = 0;
    int n_err = 0;
    int ptr = N - 1;
    bit tmo_exp = 1'b0;

    dpo_arb_if #(.N_PORTS(N)) bus ();

    dpo_arb #(
        .N_PORTS(N),
        .ADDR_OFS(2'd1),
        .SETUP_CYC(SETUP),
        .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .en_i(en),
        .bus(bus),
        .busy_o(busy),
        .tmout_o(tmout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] r);
        for (int i = 1; i <= N; i++) begin
            if (((r >> ((ptr + i) % N)) & 3'b001) != 3'b000)
                return (ptr + i) % N;
        end
        return -1;
    endfunction

    // Starts at a negedge in IDLE; returns at a negedge back in IDLE.
    // dly: done[g] sampled dly edges after strt rises; outside 1..TMO = never.
    task automatic grant(input logic [2:0] r, input int dly,
                         output int g);
        int t;
        logic [2:0] oh;
        bit to;
        g = pick(r);
        oh = 3'(1 << g);
        to = (dly < 1 || dly > TMO);
        bus.req = r;
        en = 1'b1;
        bus.done = '0;
        @(posedge clk); #1;
        chk("grant_sel", 32'(bus.sel), 32'(oh));
        chk("grant_addr", 32'(bus.fx3_addr), (1 + g) % 4);
        chk("grant_busy", 32'(busy), 1);
        t = 0;
        while (bus.strt === 3'b000 && t < 20) begin
            @(negedge clk);
            bus.req = 3'($urandom);
            @(posedge clk); #1;
            t++;
        end
        chk("strt_lat", t, SETUP + 1);
        chk("strt_oh", 32'(bus.strt), 32'(oh));
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            bus.req = 3'($urandom);
            en = 1'($urandom);
            bus.done = 3'($urandom) & ~oh;
            if (k == dly) bus.done = bus.done | oh;
            @(posedge clk); #1;
            chk("wd_sel", 32'(bus.sel), 32'(oh));
            chk("wd_addr", 32'(bus.fx3_addr), (1 + g) % 4);
            chk("wd_strt", 32'(bus.strt), 0);
            if (k < TMO) chk("wd_tmout", 32'(tmout), 32'(tmo_exp));
            if (k == dly) break;
        end
        if (to) tmo_exp = 1'b1;
        chk("rel_tmout", 32'(tmout), 32'(tmo_exp));
        chk("rel_busy", 32'(busy), 1);
        @(negedge clk);
        bus.done = 3'($urandom);
        bus.req = 3'($urandom);
        @(posedge clk); #1;
        chk("rel_sel", 32'(bus.sel), 0);
        chk("rel_idle", 32'(busy), 0);
        ptr = g;
        @(negedge clk);
        bus.done = '0;
    endtask

    task automatic idle(input logic [2:0] r, input bit e);
        bus.req = r;
        en = e;
        bus.done = 3'($urandom);
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_sel", 32'(bus.sel), 0);
        chk("idle_strt", 32'(bus.strt), 0);
        @(negedge clk);
    endtask

    initial begin
        int g;
        logic [2:0] r;
        bit e;
        rst_n = 1'b0;
        en = 1'b0;
        bus.req = '0;
        bus.done = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sel", 32'(bus.sel), 0);
        chk("rst_strt", 32'(bus.strt), 0);
        chk("rst_addr", 32'(bus.fx3_addr), 1);
        chk("rst_tmout", 32'(tmout), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 50; i++) idle(3'b000, 1'b1);

        for (int i = 0; i < 6; i++) begin
            grant(3'b111, 5, g);
            chk("rr_order", g, i % N);
        end

        for (int i = 0; i < 4; i++) begin
            grant(3'b010, 2, g);
            chk("single_port", g, 1);
        end

        for (int i = 0; i < 60; i++) begin
            r = 3'($urandom);
            e = (($urandom % 4) != 0);
            if (e && r != 3'b000) grant(r, int'($urandom_range(1, 8)), g);
            else idle(r, e);
        end

        grant(3'b011, TMO, g);
        chk("coinc_tmout", 32'(tmout), 0);

        grant(3'b100, 0, g);
        chk("tmo_port", g, 2);
        chk("tmo_flag", 32'(tmout), 1);
        grant(3'b111, 3, g);
        chk("after_tmo", g, 0);

        bus.req = 3'b111;
        en = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sel", 32'(bus.sel), 0);
        chk("arst_strt", 32'(bus.strt), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_tmout", 32'(tmout), 0);
        chk("arst_addr", 32'(bus.fx3_addr), 1);
        @(negedge clk);
        rst_n = 1'b1;
        ptr = N - 1;
        tmo_exp = 1'b0;
        grant(3'b111, 4, g);
        chk("post_rst_first", g, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
